// File: rtl/spi_slave_regfile_if.sv
// SPI pad-side signal bundle for spi_slave_regfile.
// The master modport is the external SPI master; the slave modport is the register-file block.
interface spi_slave_regfile_if;
   logic s_sck;
   logic s_mosi;
   logic s_ss;
   logic s_miso;
   logic s_miso_oe;

   modport master (
      output s_sck,
      output s_mosi,
      output s_ss,
      input  s_miso,
      input  s_miso_oe
   );

   modport slave (
      input  s_sck,
      input  s_mosi,
      input  s_ss,
      output s_miso,
      output s_miso_oe
   );
endinterface

// File: rtl/spi_slave_regfile.sv
// Oversampled mode-0 SPI slave exposing NUM_REGS 8-bit registers via {rw, addr[6:0]}, data frames.
// Optional macro SPI_SLAVE_BURST_EN: auto-incrementing multi-byte bursts instead of a single data byte.
module spi_slave_regfile #(
   parameter int         NUM_REGS    = 8,
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter logic [7:0] RESET_VALUE = 8'h00
) (
   input  logic                  FAB_CCC_GL0,
   input  logic                  FAB_RESET,
   spi_slave_regfile_if.slave    spi,
   output logic [NUM_REGS*8-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic [7:0]            wr_data
);

   localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_sck_sync;
   logic [1:0]  r_mosi_sync;
   logic [1:0]  r_ss_sync;
   logic [6:0]  r_shift;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_tx;
   logic        r_miso;
   logic        r_miso_oe;
   logic        r_skip_fall;
   logic        r_need_ss_high;
   logic        r_rw;
   logic [6:0]  r_addr;
   logic        r_wr_strobe;
   logic [6:0]  r_wr_addr;
   logic [7:0]  r_wr_data;
   logic [7:0]  r_regs [NUM_REGS];

   logic        w_sck_rise;
   logic        w_sck_fall;
   logic        w_mosi;
   logic        w_ss;
   logic        w_last;
   logic [6:0]  w_cmd_addr;
   logic [6:0]  w_rd_addr;
   logic [7:0]  w_rd_val;
   logic [7:0]  w_byte;
   logic        w_clear;
   logic        w_shift;
   logic        w_cmd_done;
   logic        w_byte_done;
   logic        w_tx_shift;
   logic        w_skip_clr;

   function automatic logic addr_ok(input logic [6:0] a);
      return ({1'b0, a} < NUM_REGS_B);
   endfunction

   // NOTE: synchroniser flops carry no reset so they keep sampling the pins during FAB_RESET;
   // a reset value on s_ss would fake a high level and defeat the mid-frame reset guard.
   always_ff @(posedge FAB_CCC_GL0) begin
      r_sck_sync  <= {r_sck_sync[1:0], spi.s_sck};
      r_mosi_sync <= {r_mosi_sync[0], spi.s_mosi};
      r_ss_sync   <= {r_ss_sync[0], spi.s_ss};
   end

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
   assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
   assign w_mosi     = r_mosi_sync[1];
   assign w_ss       = r_ss_sync[1];
   assign w_last     = (r_bit_cnt == 3'd7);
   assign w_cmd_addr = {r_shift[5:0], w_mosi};
   assign w_byte     = {r_shift, w_mosi};

`ifdef SPI_SLAVE_BURST_EN
   function automatic logic [6:0] next_addr(input logic [6:0] a);
      return (a >= 7'h7E) ? 7'h00 : a + 7'd1;
   endfunction

   assign w_rd_addr = (r_state == ST_CMD) ? w_cmd_addr : next_addr(r_addr);
`else
   assign w_rd_addr = w_cmd_addr;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_rd_val = 8'h00;
      if (addr_ok(w_rd_addr)) begin
         w_rd_val = r_regs[w_rd_addr[AW-1:0]];
      end else if (w_rd_addr == 7'h7F) begin
         w_rd_val = ID_VALUE;
      end
   end

   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_shift      = 1'b0;
      w_cmd_done   = 1'b0;
      w_byte_done  = 1'b0;
      w_tx_shift   = 1'b0;
      w_skip_clr   = 1'b0;
      if (w_ss) begin
         w_state_next = ST_IDLE;
         w_clear      = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_clear = 1'b1;
               if (!r_need_ss_high) w_state_next = ST_CMD;
            end
            ST_CMD: begin
               if (w_sck_rise) begin
                  w_shift = 1'b1;
                  if (w_last) begin
                     w_cmd_done   = 1'b1;
                     w_state_next = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_sck_rise) begin
                  w_shift = 1'b1;
                  if (w_last) begin
                     w_byte_done = 1'b1;
`ifdef SPI_SLAVE_BURST_EN
                     w_state_next = ST_DATA;
`else
                     w_state_next = ST_DONE;
`endif
                  end
               end
               // The fall right after a byte boundary belongs to the freshly loaded MSB.
               if (w_sck_fall) begin
                  if (r_skip_fall) w_skip_clr = 1'b1;
                  else             w_tx_shift = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the register bank is reset explicitly because firmware relies on RESET_VALUE.
   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_tx           <= '0;
         r_miso         <= 1'b0;
         r_miso_oe      <= 1'b0;
         r_skip_fall    <= 1'b0;
         r_need_ss_high <= 1'b1;
         r_rw           <= 1'b0;
         r_addr         <= '0;
         r_wr_strobe    <= 1'b0;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      end else begin
         r_wr_strobe <= 1'b0;
         r_miso_oe   <= ~w_ss;
         if (w_ss) r_need_ss_high <= 1'b0;

         if (w_clear) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_skip_fall <= 1'b0;
         end

         if (w_shift) begin
            r_shift   <= {r_shift[5:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         if (w_cmd_done) begin
            r_rw        <= r_shift[6];
            r_addr      <= w_cmd_addr;
            r_skip_fall <= 1'b1;
            r_tx        <= r_shift[6] ? w_rd_val[6:0] : 7'd0;
            r_miso      <= r_shift[6] & w_rd_val[7];
         end

         if (w_tx_shift) begin
            r_miso <= r_tx[6];
            r_tx   <= {r_tx[5:0], 1'b0};
         end

         if (w_skip_clr) r_skip_fall <= 1'b0;

         if (w_byte_done) begin
            if (!r_rw && addr_ok(r_addr)) begin
               r_regs[r_addr[AW-1:0]] <= w_byte;
               r_wr_strobe            <= 1'b1;
               r_wr_addr              <= r_addr;
               r_wr_data              <= w_byte;
            end
`ifdef SPI_SLAVE_BURST_EN
            r_addr      <= next_addr(r_addr);
            r_skip_fall <= 1'b1;
            r_tx        <= r_rw ? w_rd_val[6:0] : 7'd0;
            r_miso      <= r_rw & w_rd_val[7];
`else
            r_miso      <= 1'b0;
`endif
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[8*gi +: 8] = r_regs[gi];
   end

   assign spi.s_miso    = r_miso;
   assign spi.s_miso_oe = r_miso_oe;
   assign wr_strobe     = r_wr_strobe;
   assign wr_addr       = r_wr_addr;
   assign wr_data       = r_wr_data;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomised frame-level bench for spi_slave_regfile against a register-array model.
// Expectations follow SPI_SLAVE_BURST_EN when the macro is defined for the build.
module tb_spi_slave_regfile;
   localparam int NUM_REGS = 8;
`ifdef SPI_SLAVE_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REGS*8-1:0] reg_out;
   logic                  wr_strobe;
   logic [6:0]            wr_addr;
   logic [7:0]            wr_data;

   always #5 clk = ~clk;

   spi_slave_regfile_if spi_if ();

   spi_slave_regfile #(
      .NUM_REGS    (NUM_REGS),
      .ID_VALUE    (8'hA5),
      .RESET_VALUE (8'h00)
   ) dut (
      .FAB_CCC_GL0 (clk),
      .FAB_RESET   (rst),
      .spi         (spi_if),
      .reg_out     (reg_out),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  m_regs [NUM_REGS];
   logic [7:0]  tx_b [4];
   logic [7:0]  rx_b [4];
   logic [14:0] strobe_q [$];
   logic [14:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
   end

   function automatic logic [7:0] m_read(input logic [6:0] a);
      if (a < NUM_REGS) return m_regs[a];
      if (a == 7'h7F)   return 8'hA5;
      return 8'h00;
   endfunction

   task automatic half_period();
      repeat (6) @(negedge clk);
   endtask

   // Master side: stop_bits < 0 runs the whole frame; rst_bits >= 0 pulses reset before that bit.
   task automatic spi_frame(input int nbytes, input int stop_bits, input int rst_bits);
      int bit_no = 0;
      spi_if.s_ss = 1'b0;
      repeat (8) @(negedge clk);
      check("miso_oe_active", 32'(spi_if.s_miso_oe), 32'd1);
      for (int b = 0; b < nbytes; b++) begin
         rx_b[b] = 8'h00;
         for (int i = 7; i >= 0; i--) begin
            if (bit_no != stop_bits) begin
               if (bit_no == rst_bits) begin
                  rst = 1'b1;
                  repeat (2) @(negedge clk);
                  rst = 1'b0;
               end
               spi_if.s_mosi = tx_b[b][i];
               half_period();
               spi_if.s_sck = 1'b1;
               rx_b[b][i] = spi_if.s_miso;
               half_period();
               spi_if.s_sck = 1'b0;
               bit_no++;
            end
         end
      end
      half_period();
      spi_if.s_ss = 1'b1;
      repeat (8) @(negedge clk);
      check("miso_oe_idle", 32'(spi_if.s_miso_oe), 32'd0);
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < NUM_REGS; r++) check(tag, 32'(reg_out[8*r +: 8]), 32'(m_regs[r]));
   endtask

   task automatic check_strobes();
      check("strobe_count", 32'(strobe_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++)
         check("strobe_addr_data", 32'(strobe_q[i]), 32'(exp_q[i]));
   endtask

   task automatic do_frame(input int nbytes, input int stop_bits);
      logic [7:0] exp_rx [4];
      logic [6:0] a;
      logic       rw;
      logic       active;
      a  = tx_b[0][6:0];
      rw = tx_b[0][7];
      exp_rx[0] = 8'h00;
      exp_q.delete();
      for (int k = 1; k < nbytes; k++) begin
         active    = (k == 1) || BURST;
         exp_rx[k] = (active && rw) ? m_read(a) : 8'h00;
         if (active && !rw && a < NUM_REGS && (stop_bits < 0 || stop_bits >= 8 * (k + 1))) begin
            m_regs[a] = tx_b[k];
            exp_q.push_back({a, tx_b[k]});
         end
         if (active) a = (a >= 7'h7E) ? 7'h00 : a + 7'd1;
      end
      strobe_q.delete();
      spi_frame(nbytes, stop_bits, -1);
      if (stop_bits < 0) begin
         for (int k = 0; k < nbytes; k++) check("miso_byte", 32'(rx_b[k]), 32'(exp_rx[k]));
      end
      check_strobes();
      check_regs("reg_out");
   endtask

   initial begin
      spi_if.s_sck  = 1'b0;
      spi_if.s_mosi = 1'b0;
      spi_if.s_ss   = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) m_regs[r] = 8'h00;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_miso",      32'(spi_if.s_miso),    32'd0);
      check("rst_miso_oe",   32'(spi_if.s_miso_oe), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe),        32'd0);
      check("rst_wr_addr",   32'(wr_addr),          32'd0);
      check("rst_wr_data",   32'(wr_data),          32'd0);
      check_regs("rst_reg_out");
      repeat (4) @(negedge clk);

      tx_b[0] = 8'h80; tx_b[1] = 8'h00; do_frame(2, -1);
      tx_b[0] = 8'h03; tx_b[1] = 8'h5C; do_frame(2, -1);
      check("reg3_byte", 32'(reg_out[31:24]), 32'h5C);
      tx_b[0] = 8'h83; tx_b[1] = 8'h00; do_frame(2, -1);
      tx_b[0] = 8'hFF; tx_b[1] = 8'h00; do_frame(2, -1);
      tx_b[0] = 8'h7F; tx_b[1] = 8'h12; do_frame(2, -1);
      tx_b[0] = 8'h0A; tx_b[1] = 8'h34; do_frame(2, -1);

      tx_b[0] = 8'h01; tx_b[1] = 8'hC3; do_frame(2, 13);
      tx_b[0] = 8'h01; tx_b[1] = 8'h3C; do_frame(2, -1);

      // Reset lands inside byte1 while s_ss stays low; the tail of the frame must be ignored.
      tx_b[0] = 8'h02; tx_b[1] = 8'h77;
      strobe_q.delete();
      exp_q.delete();
      spi_frame(2, -1, 10);
      for (int r = 0; r < NUM_REGS; r++) m_regs[r] = 8'h00;
      check_strobes();
      check_regs("rst_mid_reg_out");
      tx_b[0] = 8'h04; tx_b[1] = 8'h99; do_frame(2, -1);
      tx_b[0] = 8'h84; tx_b[1] = 8'h00; do_frame(2, -1);

      tx_b[0] = 8'h02; tx_b[1] = 8'h11; tx_b[2] = 8'h22; tx_b[3] = 8'h33; do_frame(4, -1);
      tx_b[0] = 8'h82; tx_b[1] = 8'h00; tx_b[2] = 8'h00; tx_b[3] = 8'h00; do_frame(4, -1);

      for (int n = 0; n < 40; n++) begin
         int sel;
         logic [6:0] a;
         sel = int'($urandom_range(0, 11));
         if (sel == 10)      a = 7'h7F;
         else if (sel == 11) a = 7'h7E;
         else                a = 7'(sel);
         tx_b[0] = {1'($urandom_range(0, 1)), a};
         for (int k = 1; k < 4; k++) tx_b[k] = 8'($urandom);
         do_frame(int'($urandom_range(2, 4)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
